bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Shares one downstream OCP-style `Bus` slave between `NUM_MASTERS` upstream masters. Selects a request round-robin and holds the grant until `SCmdAccept`. Records the granted master ID in an in-order FIFO, so each downstream response goes back to the master that issued the command. Sits between CPU/DMA masters and a single memory or peripheral slave port.

## Interface
Parameters:
- `NUM_MASTERS`, 4, number of upstream masters (2..8)
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width (multiple of 8)
- `MAX_OUTSTANDING`, 4, accepted-but-unanswered commands (power of 2, ≥2)
- `WRITE_RESP`, 1'b1, writes receive a response; when 0, only reads are tracked

Ports (`N`=`NUM_MASTERS`, `B`=`DATA_WIDTH/8`):
- `Clk`  in  1  clock
- `Reset_n`  in  1  reset; one clock, asynchronous, active-low
- `M_MCmd`  in  N×`Bus::Ocp_cmd`  upstream commands
- `M_MAddr`  in  N×`ADDR_WIDTH`  upstream addresses
- `M_MData`  in  N×`DATA_WIDTH`  upstream write data
- `M_MByteEn`  in  N×B  upstream byte enables
- `M_MRespAccept`  in  N  upstream response accept
- `M_SCmdAccept`  out  N  command accept to each master
- `M_SResp`  out  N×`Bus::Ocp_resp`  response to each master
- `M_SData`  out  N×`DATA_WIDTH`  read data to each master
- `S_MReset_n`  out  1  equals `Reset_n`
- `S_MCmd`, `S_MAddr`, `S_MData`, `S_MByteEn`, `S_MRespAccept`  out  per `Bus`  downstream request and accept
- `S_SCmdAccept`, `S_SResp`, `S_SData`  in  per `Bus`  downstream accept and response
- `Err_unexpected_resp`  out  1  sticky; a response arrived with no command outstanding

## Operation
- A master requests when `M_MCmd[i] != Bus::IDLE`.
- Grant states:
  - UNLOCKED:
    - If the FIFO is not full, a combinational round-robin pick starts at `last+1`; the winner is forwarded to the `S_*` request signals.
    - If `S_SCmdAccept` is high, the accept goes to the winner only; `last` becomes the winner and the ID is pushed (writes are pushed only when `WRITE_RESP`).
    - If `S_SCmdAccept` is low, go to LOCKED(winner).
  - LOCKED(k):
    - Forward master k regardless of other requests.
    - On `S_SCmdAccept`: push k, `last`=k, go to UNLOCKED.
- FIFO full while UNLOCKED: `S_MCmd`=IDLE and all `M_SCmdAccept`=0. LOCKED cannot coincide with a full FIFO, because entry to LOCKED requires a free slot.
- No winner: `S_MCmd`=IDLE; `S_MAddr`/`S_MData`/`S_MByteEn`=0.
- Responses:
  - Head ID h: `M_SResp[h]`=`S_SResp`, `M_SData[h]`=`S_SData`, `S_MRespAccept`=`M_MRespAccept[h]`.
  - All other masters get `Bus::NULL` and zero data.
  - Pop when `S_SResp != Bus::NULL && S_MRespAccept`.
- FIFO empty and `S_SResp != NULL`: no master sees it, `S_MRespAccept`=1 (drain), `Err_unexpected_resp`←1 until reset.
- Push and pop in the same cycle: occupancy unchanged. A push is allowed when full-and-popping only if the FIFO is not full at cycle start (full check is registered; no bypass).

## Timing
- Request path and response path: combinational, zero added latency.
- Reset values (Reset_n low, any time): UNLOCKED; `last`=`N-1` (master 0 has first priority); FIFO empty; `Err_unexpected_resp`=0.
- Outputs during reset: `S_MCmd`=IDLE, all `M_SCmdAccept`=0, all `M_SResp`=NULL, `S_MRespAccept`=0.
- Reset mid-transaction discards the lock and all outstanding IDs.
- Request stability: the forwarded request is constant from first presentation until `S_SCmdAccept`, provided the upstream master obeys the same rule.
- Fairness: a continuously requesting master is granted within `N` accepts.

## Structure
- Use the existing `Bus` package types `Ocp_cmd`/`Ocp_resp`.
- Add `Bus::rr_pick` (function: request vector, last → winner index, valid) to the package for reuse by other arbiters.
- Local `ID_WIDTH = $clog2(NUM_MASTERS)`.
- One sub-module, `bus_arb_id_fifo`: synchronous FIFO, depth `MAX_OUTSTANDING`, width `ID_WIDTH`, with registered full/empty, push, pop, and head output.

## Test plan
- Masters 0 and 2 both issue reads at cycle 0, slave accepts every cycle → master 0 accepted at cycle 0, master 2 at cycle 1. Responses DVA/0xA, DVA/0xB reach masters 0 and 2 respectively.
- Master 1 requests, `S_SCmdAccept` held low for 3 cycles while master 3 also requests → `S_MAddr` stays master 1's value for all 4 cycles. Master 3 is accepted next.
- All 4 masters stream reads, slave never responds → exactly 4 accepts, then `S_MCmd`=IDLE. One response with `MRespAccept` → one further accept in the same-or-next cycle per registered full.
- Response arrives while head master holds `M_MRespAccept`=0 for 2 cycles → `S_MRespAccept`=0 and no pop. Pop happens in the cycle it goes 1.
- `S_SResp`=DVA with FIFO empty → no master sees it, `Err_unexpected_resp`=1 from the next cycle until `Reset_n` is asserted.
- `Reset_n` asserted during LOCKED with 2 outstanding → immediate IDLE/NULL outputs. After release, master 0 has priority and the FIFO is empty.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Bus: shared OCP-style command/response types plus the round-robin helper
// used by arbiters that sit in front of a single slave port.
package Bus;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2
  } Ocp_cmd;

  typedef enum logic [1:0] {
    NULL = 2'd0,
    DVA  = 2'd1,
    ERR  = 2'd3
  } Ocp_resp;

  localparam int RR_MAX = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } Rr_pick;

  // Scans n requesters starting just after 'last', wrapping at n.
  function automatic Rr_pick rr_pick(input logic [RR_MAX-1:0] req,
                                     input logic [2:0]        last,
                                     input int                n);
    Rr_pick r;
    int     c;
    r = '0;
    for (int off = 1; off <= RR_MAX; off++) begin
      c = int'(last) + off;
      if (c >= n) c = c - n;
      if (off <= n && !r.valid && req[c[2:0]]) begin
        r.valid = 1'b1;
        r.idx   = c[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of granted master IDs; full/empty are registered so a push
// is refused whenever the FIFO was full at the start of the cycle.
module bus_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_id,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             do_push, do_pop;

  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
  assign head       = mem[rd_ptr];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one OCP-style slave between several masters;
// responses are steered back using the in-order ID FIFO.
module bus_arbiter
  import Bus::*;
#(
  parameter int   NUM_MASTERS     = 4,
  parameter int   ADDR_WIDTH      = 32,
  parameter int   DATA_WIDTH      = 32,
  parameter int   MAX_OUTSTANDING = 4,
  parameter logic WRITE_RESP      = 1'b1
) (
  input  logic                                       Clk,
  input  logic                                       Reset_n,
  input  Bus::Ocp_cmd  [NUM_MASTERS-1:0]             M_MCmd,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]     M_MAddr,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]     M_MData,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]   M_MByteEn,
  input  logic [NUM_MASTERS-1:0]                     M_MRespAccept,
  output logic [NUM_MASTERS-1:0]                     M_SCmdAccept,
  output Bus::Ocp_resp [NUM_MASTERS-1:0]             M_SResp,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]     M_SData,
  output logic                                       S_MReset_n,
  output Bus::Ocp_cmd                                S_MCmd,
  output logic [ADDR_WIDTH-1:0]                      S_MAddr,
  output logic [DATA_WIDTH-1:0]                      S_MData,
  output logic [DATA_WIDTH/8-1:0]                    S_MByteEn,
  output logic                                       S_MRespAccept,
  input  logic                                       S_SCmdAccept,
  input  Bus::Ocp_resp                               S_SResp,
  input  logic [DATA_WIDTH-1:0]                      S_SData,
  output logic                                       Err_unexpected_resp
);

  localparam int ID_WIDTH = $clog2(NUM_MASTERS);
  localparam int RR_W     = Bus::RR_MAX;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} Grant_state;

  Grant_state          state, state_next;
  logic [ID_WIDTH-1:0] last, last_next, lock_id, lock_id_next, sel_id, fifo_head;
  logic                sel_valid, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                unexpected;
  logic [NUM_MASTERS-1:0] req;
  Bus::Rr_pick         pick;
  logic                unused_pick;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) req[i] = (M_MCmd[i] != Bus::IDLE);
  end

  assign pick        = Bus::rr_pick(RR_W'(req), 3'(last), NUM_MASTERS);
  assign unused_pick = ^pick.idx;
  assign S_MReset_n  = Reset_n;

  // Request side: a lock pins the forwarded master until the slave accepts.
  always_comb begin
    state_next   = state;
    last_next    = last;
    lock_id_next = lock_id;
    sel_valid    = 1'b0;
    sel_id       = '0;
    fifo_push    = 1'b0;
    S_MCmd       = Bus::IDLE;
    S_MAddr      = '0;
    S_MData      = '0;
    S_MByteEn    = '0;
    M_SCmdAccept = '0;
    if (Reset_n) begin
      if (state == LOCKED) begin
        sel_id    = lock_id;
        sel_valid = req[lock_id];
        if (!req[lock_id]) state_next = UNLOCKED;
      end else if (!fifo_full && pick.valid) begin
        sel_id    = ID_WIDTH'(pick.idx);
        sel_valid = 1'b1;
      end
    end
    if (sel_valid) begin
      S_MCmd    = M_MCmd[sel_id];
      S_MAddr   = M_MAddr[sel_id];
      S_MData   = M_MData[sel_id];
      S_MByteEn = M_MByteEn[sel_id];
      if (S_SCmdAccept) begin
        M_SCmdAccept[sel_id] = 1'b1;
        last_next  = sel_id;
        state_next = UNLOCKED;
        fifo_push  = (M_MCmd[sel_id] == Bus::RD) ||
                     (WRITE_RESP && M_MCmd[sel_id] == Bus::WR);
      end else begin
        state_next   = LOCKED;
        lock_id_next = sel_id;
      end
    end
  end

  // Response side: with nothing outstanding, the response is drained and flagged.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) M_SResp[i] = Bus::NULL;
    M_SData       = '0;
    S_MRespAccept = 1'b0;
    fifo_pop      = 1'b0;
    unexpected    = 1'b0;
    if (Reset_n) begin
      if (!fifo_empty) begin
        M_SResp[fifo_head] = S_SResp;
        M_SData[fifo_head] = S_SData;
        S_MRespAccept      = M_MRespAccept[fifo_head];
        fifo_pop           = (S_SResp != Bus::NULL) && M_MRespAccept[fifo_head];
      end else begin
        S_MRespAccept = 1'b1;
        unexpected    = (S_SResp != Bus::NULL);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state               <= UNLOCKED;
      last                <= ID_WIDTH'(NUM_MASTERS - 1);
      lock_id             <= '0;
      Err_unexpected_resp <= 1'b0;
    end else begin
      state   <= state_next;
      last    <= last_next;
      lock_id <= lock_id_next;
      if (unexpected) Err_unexpected_resp <= 1'b1;
    end
  end

  bus_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_WIDTH)
  ) u_id_fifo (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .push    (fifo_push),
    .push_id (sel_id),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: grant order, lock hold, FIFO full
// back-pressure, response routing via a scoreboard, and reset behaviour.
module tb_bus_arbiter;
  import Bus::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  Bus::Ocp_cmd  [N-1:0]         m_cmd;
  logic [N-1:0][AW-1:0]         m_addr;
  logic [N-1:0][DW-1:0]         m_data;
  logic [N-1:0][BW-1:0]         m_be;
  logic [N-1:0]                 m_resp_accept;
  logic [N-1:0]                 m_cmd_accept;
  Bus::Ocp_resp [N-1:0]         m_resp;
  logic [N-1:0][DW-1:0]         m_sdata;
  logic                         s_reset_n;
  Bus::Ocp_cmd                  s_cmd;
  logic [AW-1:0]                s_addr;
  logic [DW-1:0]                s_data;
  logic [BW-1:0]                s_be;
  logic                         s_resp_accept;
  logic                         s_cmd_accept;
  Bus::Ocp_resp                 s_resp;
  logic [DW-1:0]                s_sdata;
  logic                         err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int            master;
    logic [DW-1:0] data;
  } Exp_resp;

  Exp_resp exp_q[$];
  logic [N-1:0] t3_pat [6];

  always #5 Clk = ~Clk;

  bus_arbiter #(
    .NUM_MASTERS (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW),
    .MAX_OUTSTANDING (4), .WRITE_RESP (1'b1)
  ) dut (
    .Clk (Clk), .Reset_n (Reset_n),
    .M_MCmd (m_cmd), .M_MAddr (m_addr), .M_MData (m_data), .M_MByteEn (m_be),
    .M_MRespAccept (m_resp_accept), .M_SCmdAccept (m_cmd_accept),
    .M_SResp (m_resp), .M_SData (m_sdata), .S_MReset_n (s_reset_n),
    .S_MCmd (s_cmd), .S_MAddr (s_addr), .S_MData (s_data), .S_MByteEn (s_be),
    .S_MRespAccept (s_resp_accept), .S_SCmdAccept (s_cmd_accept),
    .S_SResp (s_resp), .S_SData (s_sdata), .Err_unexpected_resp (err)
  );

  task automatic check_output(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic to_drive();
    @(posedge Clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge Clk);
  endtask

  task automatic apply_stimulus(input int m, input Bus::Ocp_cmd c);
    m_cmd[m] = c;
  endtask

  task automatic drive_resp(input int m, input logic [DW-1:0] d);
    Exp_resp e;
    s_resp  = Bus::DVA;
    s_sdata = d;
    e.master = m;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic check_resp();
    Exp_resp e;
    if (exp_q.size() == 0) begin
      check_output("sb_underflow", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < N; i++) begin
      if (i == e.master) begin
        check_output($sformatf("resp_m%0d", i), 64'(m_resp[i]), 64'(Bus::DVA));
        check_output($sformatf("rdata_m%0d", i), 64'(m_sdata[i]), 64'(e.data));
      end else begin
        check_output($sformatf("idle_m%0d", i), 64'(m_resp[i]), 64'(Bus::NULL));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_cmd[i]  = Bus::IDLE;
      m_addr[i] = 32'h1000_0000 + 32'(i) * 32'h10;
      m_data[i] = 32'hD000_0000 + 32'(i);
      m_be[i]   = BW'(i + 1);
    end
    m_resp_accept = '1;
    s_cmd_accept  = 1'b0;
    s_resp        = Bus::DVA;
    s_sdata       = '0;
    t3_pat = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    apply_stimulus(0, Bus::RD);

    // Reset state with a request and a response already present
    #12;
    check_output("rst_cmd", 64'(s_cmd), 64'(Bus::IDLE));
    check_output("rst_acc", 64'(m_cmd_accept), 64'd0);
    check_output("rst_racc", 64'(s_resp_accept), 64'd0);
    check_output("rst_resp0", 64'(m_resp[0]), 64'(Bus::NULL));
    check_output("rst_err", 64'(err), 64'd0);
    check_output("rst_sreset", 64'(s_reset_n), 64'd0);
    s_resp = Bus::NULL;
    @(negedge Clk);
    Reset_n = 1'b1;

    // Two simultaneous readers, slave accepts every cycle
    to_drive();
    apply_stimulus(0, Bus::RD);
    apply_stimulus(2, Bus::RD);
    s_cmd_accept = 1'b1;
    to_sample();
    check_output("t1_acc0", 64'(m_cmd_accept), 64'b0001);
    check_output("t1_addr0", 64'(s_addr), 64'h1000_0000);
    check_output("t1_data0", 64'(s_data), 64'hD000_0000);
    check_output("t1_be0", 64'(s_be), 64'h1);
    check_output("t1_cmd", 64'(s_cmd), 64'(Bus::RD));
    to_drive();
    apply_stimulus(0, Bus::IDLE);
    to_sample();
    check_output("t1_acc2", 64'(m_cmd_accept), 64'b0100);
    check_output("t1_addr2", 64'(s_addr), 64'h1000_0020);
    to_drive();
    apply_stimulus(2, Bus::IDLE);
    s_cmd_accept = 1'b0;
    drive_resp(0, 32'hA);
    to_sample();
    check_resp();
    check_output("t1_racc", 64'(s_resp_accept), 64'd1);
    to_drive();
    drive_resp(2, 32'hB);
    to_sample();
    check_resp();

    // Lock held on master 1 while master 3 waits
    to_drive();
    s_resp = Bus::NULL;
    apply_stimulus(1, Bus::RD);
    to_sample();
    check_output("t2_hold0", 64'(s_addr), 64'h1000_0010);
    check_output("t2_noacc", 64'(m_cmd_accept), 64'd0);
    for (int k = 1; k < 4; k++) begin
      to_drive();
      apply_stimulus(3, Bus::RD);
      to_sample();
      check_output($sformatf("t2_hold%0d", k), 64'(s_addr), 64'h1000_0010);
    end
    to_drive();
    s_cmd_accept = 1'b1;
    to_sample();
    check_output("t2_acc1", 64'(m_cmd_accept), 64'b0010);
    to_drive();
    apply_stimulus(1, Bus::IDLE);
    to_sample();
    check_output("t2_acc3", 64'(m_cmd_accept), 64'b1000);
    check_output("t2_addr3", 64'(s_addr), 64'h1000_0030);
    to_drive();
    apply_stimulus(3, Bus::IDLE);
    s_cmd_accept = 1'b0;
    drive_resp(1, 32'hC);
    to_sample();
    check_resp();
    to_drive();
    drive_resp(3, 32'hD);
    to_sample();
    check_resp();

    // All masters stream reads; the FIFO fills and blocks further grants
    to_drive();
    s_resp = Bus::NULL;
    for (int i = 0; i < N; i++) apply_stimulus(i, Bus::RD);
    s_cmd_accept = 1'b1;
    for (int k = 0; k < 6; k++) begin
      to_sample();
      check_output($sformatf("t3_acc%0d", k), 64'(m_cmd_accept), 64'(t3_pat[k]));
      if (k >= 4) check_output($sformatf("t3_idle%0d", k), 64'(s_cmd), 64'(Bus::IDLE));
      to_drive();
    end
    drive_resp(0, 32'hE);
    to_sample();
    check_resp();
    check_output("t3_fullacc", 64'(m_cmd_accept), 64'd0);
    to_drive();
    s_resp = Bus::NULL;
    to_sample();
    check_output("t3_refill", 64'(m_cmd_accept), 64'b0001);
    to_drive();
    for (int i = 0; i < N; i++) apply_stimulus(i, Bus::IDLE);
    s_cmd_accept = 1'b0;

    // Head master (1) withholds its response accept for two cycles
    m_resp_accept[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_resp(1, 32'hF);
      to_sample();
      check_resp();
      check_output($sformatf("t4_hold%0d", k), 64'(s_resp_accept), 64'd0);
      to_drive();
    end
    m_resp_accept[1] = 1'b1;
    drive_resp(1, 32'hF);
    to_sample();
    check_resp();
    check_output("t4_release", 64'(s_resp_accept), 64'd1);
    for (int k = 0; k < 3; k++) begin
      to_drive();
      drive_resp((k + 2) % N, 32'h100 + 32'(k));
      to_sample();
      check_resp();
    end

    // Response with nothing outstanding
    to_drive();
    s_resp  = Bus::DVA;
    s_sdata = 32'h55;
    to_sample();
    for (int i = 0; i < N; i++)
      check_output($sformatf("t5_null_m%0d", i), 64'(m_resp[i]), 64'(Bus::NULL));
    check_output("t5_drain", 64'(s_resp_accept), 64'd1);
    check_output("t5_err_now", 64'(err), 64'd0);
    to_drive();
    s_resp = Bus::NULL;
    to_sample();
    check_output("t5_err", 64'(err), 64'd1);
    to_drive();
    to_sample();
    check_output("t5_err_sticky", 64'(err), 64'd1);
    Reset_n = 1'b0;
    #1;
    check_output("t5_err_clr", 64'(err), 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Reset while locked with two outstanding
    to_drive();
    apply_stimulus(0, Bus::RD);
    apply_stimulus(1, Bus::RD);
    s_cmd_accept = 1'b1;
    to_sample();
    check_output("t6_acc0", 64'(m_cmd_accept), 64'b0001);
    to_drive();
    apply_stimulus(0, Bus::IDLE);
    to_sample();
    check_output("t6_acc1", 64'(m_cmd_accept), 64'b0010);
    to_drive();
    apply_stimulus(1, Bus::IDLE);
    apply_stimulus(2, Bus::RD);
    s_cmd_accept = 1'b0;
    to_sample();
    check_output("t6_pick2", 64'(s_addr), 64'h1000_0020);
    to_drive();
    apply_stimulus(0, Bus::RD);
    apply_stimulus(3, Bus::RD);
    to_sample();
    check_output("t6_locked", 64'(s_addr), 64'h1000_0020);
    Reset_n = 1'b0;
    s_resp  = Bus::DVA;
    #1;
    check_output("t6_rst_cmd", 64'(s_cmd), 64'(Bus::IDLE));
    check_output("t6_rst_acc", 64'(m_cmd_accept), 64'd0);
    check_output("t6_rst_racc", 64'(s_resp_accept), 64'd0);
    check_output("t6_rst_resp0", 64'(m_resp[0]), 64'(Bus::NULL));
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    check_output("t6_prio", 64'(s_addr), 64'h1000_0000);
    check_output("t6_empty_m0", 64'(m_resp[0]), 64'(Bus::NULL));
    check_output("t6_empty_racc", 64'(s_resp_accept), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
